// File: rtl/mtr_pkg.sv
// rtl/mtr_pkg.sv - shared state encoding, duty constants and speed saturation for the motor PWM controller
package mtr_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        RAMP_DN  = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [10:0] DUTY_MID   = 11'h400;
    localparam logic [10:0] NONOVERLAP = 11'h040;
    // Headroom of NONOVERLAP at both rails keeps duty inside [64,1983].
    localparam int          SAT_MAG    = 1024 - int'(NONOVERLAP);

    function automatic logic signed [11:0] sat_spd(input logic signed [11:0] spd);
        logic signed [11:0] hi;
        logic signed [11:0] lo;
        hi = 12'(SAT_MAG - 1);
        lo = 12'(-SAT_MAG);
        if (spd > hi) begin
            return hi;
        end else if (spd < lo) begin
            return lo;
        end
        return spd;
    endfunction

endpackage

// File: rtl/mtr_pwm_ctrl_duty_slew.sv
// rtl/mtr_pwm_ctrl_duty_slew.sv - saturated, slew-limited duty register for one motor
module duty_slew
    import mtr_pkg::*;
#(
    parameter logic [10:0] MAX_STEP = 11'd32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd,
    input  logic               force_mid,
    input  logic signed [11:0] spd,
    output logic        [10:0] duty
);

    localparam logic signed [12:0] STEP_S = $signed({2'b00, MAX_STEP});

    logic signed [11:0] spd_sat;
    logic signed [12:0] tgt;
    logic signed [12:0] diff;
    logic        [10:0] nxt;

    always_comb begin
        spd_sat = sat_spd(spd);
        tgt     = 13'sh400 + $signed({spd_sat[11], spd_sat});
        diff    = tgt - $signed({2'b00, duty});
        if (diff > STEP_S) begin
            nxt = duty + MAX_STEP;
        end else if (diff < -STEP_S) begin
            nxt = duty - MAX_STEP;
        end else begin
            nxt = tgt[10:0];
        end
    end

    // force_mid snaps to mid-scale regardless of the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= DUTY_MID;
        end else if (force_mid) begin
            duty <= DUTY_MID;
        end else if (upd) begin
            duty <= nxt;
        end
    end

endmodule

// File: rtl/mtr_pwm_ctrl.sv
// rtl/mtr_pwm_ctrl.sv - left/right motor duty sequencing, over-current windowing and enable/fault FSM
module mtr_pwm_ctrl
    import mtr_pkg::*;
#(
    parameter logic [10:0] MAX_STEP    = 11'd32,
    parameter int          WIN_PERIODS = 16,
    parameter int          OVR_LIMIT   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               pwm_synch,
    input  logic               ovr_I_blank,
    input  logic               OVR_I_lft,
    input  logic               OVR_I_rght,
    input  logic               clr_fault,
    output logic        [10:0] lft_duty,
    output logic        [10:0] rght_duty,
    output logic               pwm_en,
    output logic               OVR_I_shtdwn,
    output logic               busy
);

    localparam int WIN_W = $clog2(WIN_PERIODS);
    localparam int CNT_W = $clog2(OVR_LIMIT + 1);

    state_t             state;
    logic               ovr_l_meta;
    logic               ovr_l_sync;
    logic               ovr_r_meta;
    logic               ovr_r_sync;
    logic               period_flag;
    logic               ovr_hit;
    logic               flagged;
    logic               detect_en;
    logic               fault_trig;
    logic               force_mid;
    logic               upd;
    logic signed [11:0] lft_cmd;
    logic signed [11:0] rght_cmd;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   ovr_cnt;

    assign detect_en  = (state == RUN) || (state == RAMP_DN);
    assign ovr_hit    = (ovr_l_sync | ovr_r_sync) & ~ovr_I_blank;
    assign flagged    = period_flag | ovr_hit;
    assign fault_trig = detect_en & pwm_synch & flagged & (ovr_cnt == CNT_W'(OVR_LIMIT - 1));
    assign force_mid  = (state == DISABLED) || (state == FAULT) || fault_trig;
    assign upd        = pwm_synch & detect_en;
    // Zero speed during ramp-down slews both motors back to mid-scale.
    assign lft_cmd    = (state == RUN) ? lft_spd  : '0;
    assign rght_cmd   = (state == RUN) ? rght_spd : '0;

    duty_slew #(.MAX_STEP(MAX_STEP)) u_lft_slew (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd       (upd),
        .force_mid (force_mid),
        .spd       (lft_cmd),
        .duty      (lft_duty)
    );

    duty_slew #(.MAX_STEP(MAX_STEP)) u_rght_slew (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd       (upd),
        .force_mid (force_mid),
        .spd       (rght_cmd),
        .duty      (rght_duty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_l_meta <= 1'b0;
            ovr_l_sync <= 1'b0;
            ovr_r_meta <= 1'b0;
            ovr_r_sync <= 1'b0;
        end else begin
            ovr_l_meta <= OVR_I_lft;
            ovr_l_sync <= ovr_l_meta;
            ovr_r_meta <= OVR_I_rght;
            ovr_r_sync <= ovr_r_meta;
        end
    end

    // A hit on the synch cycle itself counts toward the period being closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_flag <= 1'b0;
            win_cnt     <= '0;
            ovr_cnt     <= '0;
        end else if (!detect_en) begin
            period_flag <= 1'b0;
            win_cnt     <= '0;
            ovr_cnt     <= '0;
        end else if (pwm_synch) begin
            period_flag <= 1'b0;
            if (win_cnt == WIN_W'(WIN_PERIODS - 1)) begin
                win_cnt <= '0;
                ovr_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                ovr_cnt <= ovr_cnt + CNT_W'(flagged);
            end
        end else if (ovr_hit) begin
            period_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= DISABLED;
            pwm_en       <= 1'b0;
            OVR_I_shtdwn <= 1'b0;
            busy         <= 1'b0;
        end else if (fault_trig) begin
            state        <= FAULT;
            pwm_en       <= 1'b0;
            OVR_I_shtdwn <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (state)
                DISABLED: begin
                    if (en && pwm_synch) begin
                        state  <= RUN;
                        pwm_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= RAMP_DN;
                    end
                end
                RAMP_DN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (pwm_synch && lft_duty == DUTY_MID && rght_duty == DUTY_MID) begin
                        state  <= DISABLED;
                        pwm_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                FAULT: begin
                    if (clr_fault && !en) begin
                        state        <= DISABLED;
                        OVR_I_shtdwn <= 1'b0;
                    end
                end
                default: begin
                    state <= DISABLED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtr_pwm_ctrl.sv
// tb/tb_mtr_pwm_ctrl.sv - scoreboard bench for mtr_pwm_ctrl
module tb_mtr_pwm_ctrl;

    typedef enum int {M_DIS, M_RUN, M_RAMP, M_FLT} mstate_t;

    typedef struct {
        int l;
        int r;
        int pen;
        int sd;
        int bz;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic signed [11:0] lft_spd = '0;
    logic signed [11:0] rght_spd = '0;
    logic               pwm_synch = 1'b0;
    logic               ovr_I_blank = 1'b0;
    logic               OVR_I_lft = 1'b0;
    logic               OVR_I_rght = 1'b0;
    logic               clr_fault = 1'b0;
    logic        [10:0] lft_duty;
    logic        [10:0] rght_duty;
    logic               pwm_en;
    logic               OVR_I_shtdwn;
    logic               busy;

    int      checks = 0;
    int      failures = 0;
    exp_t    sb_q[$];
    logic    synch_q = 1'b0;
    mstate_t m_state = M_DIS;
    int      m_l = 1024;
    int      m_r = 1024;
    int      m_win = 0;
    int      m_cnt = 0;

    mtr_pwm_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .pwm_synch    (pwm_synch),
        .ovr_I_blank  (ovr_I_blank),
        .OVR_I_lft    (OVR_I_lft),
        .OVR_I_rght   (OVR_I_rght),
        .clr_fault    (clr_fault),
        .lft_duty     (lft_duty),
        .rght_duty    (rght_duty),
        .pwm_en       (pwm_en),
        .OVR_I_shtdwn (OVR_I_shtdwn),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int tgt_of(input int s);
        if (s > 959) return 1983;
        if (s < -960) return 64;
        return 1024 + s;
    endfunction

    function automatic int slew(input int d, input int t);
        if (t - d > 32) return d + 32;
        if (t - d < -32) return d - 32;
        return t;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.l   = m_l;
        e.r   = m_r;
        e.pen = (m_state == M_RUN || m_state == M_RAMP) ? 1 : 0;
        e.bz  = e.pen;
        e.sd  = (m_state == M_FLT) ? 1 : 0;
        return e;
    endfunction

    always @(posedge clk) synch_q <= pwm_synch;

    always @(negedge clk) begin
        if (synch_q && sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_lft_duty", lft_duty, e.l);
            chk("sb_rght_duty", rght_duty, e.r);
            chk("sb_pwm_en", pwm_en, e.pen);
            chk("sb_shtdwn", OVR_I_shtdwn, e.sd);
            chk("sb_busy", busy, e.bz);
        end
    end

    task automatic model_synch(input bit hit);
        if (m_state == M_RUN || m_state == M_RAMP) begin
            if (hit && m_cnt == 7) begin
                m_state = M_FLT;
                m_l = 1024;
                m_r = 1024;
                m_cnt = 0;
                m_win = 0;
                return;
            end
            if (hit) m_cnt++;
            m_win++;
            if (m_win == 16) begin
                m_win = 0;
                m_cnt = 0;
            end
        end
        case (m_state)
            M_DIS: if (en) m_state = M_RUN;
            M_RUN: begin
                m_l = slew(m_l, tgt_of(int'(lft_spd)));
                m_r = slew(m_r, tgt_of(int'(rght_spd)));
            end
            M_RAMP: begin
                if (m_l == 1024 && m_r == 1024) begin
                    m_state = M_DIS;
                    m_cnt = 0;
                    m_win = 0;
                end else begin
                    m_l = slew(m_l, 1024);
                    m_r = slew(m_r, 1024);
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_period(input bit hit, input bit blanked);
        repeat (12) @(negedge clk);
        if (hit) begin
            OVR_I_lft = 1'b1;
            @(negedge clk);
            OVR_I_lft = 1'b0;
        end
        if (blanked) begin
            ovr_I_blank = 1'b1;
            OVR_I_rght = 1'b1;
            repeat (4) @(negedge clk);
            OVR_I_rght = 1'b0;
            repeat (4) @(negedge clk);
            ovr_I_blank = 1'b0;
        end
        repeat (8) @(negedge clk);
        pwm_synch = 1'b1;
        model_synch(hit);
        sb_q.push_back(model_out());
        @(negedge clk);
        pwm_synch = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_en(input logic v);
        @(negedge clk);
        en = v;
        if (m_state == M_RUN && !v) m_state = M_RAMP;
        if (m_state == M_RAMP && v) m_state = M_RUN;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        if (m_state == M_FLT && !en) m_state = M_DIS;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_lft"}, lft_duty, 1024);
        chk({tag, "_rght"}, rght_duty, 1024);
        chk({tag, "_pwm_en"}, pwm_en, 0);
        chk({tag, "_shtdwn"}, OVR_I_shtdwn, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("after_reset");

        lft_spd = 12'sd500;
        rght_spd = -12'sd500;
        set_en(1'b1);
        repeat (3) @(negedge clk);
        chk("en_wait_pwm_en", pwm_en, 0);
        for (int i = 0; i < 20; i++) run_period(0, 0);
        chk("run_lft_1524", lft_duty, 1524);
        chk("run_rght_524", rght_duty, 524);

        set_en(1'b0);
        for (int i = 0; i < 20; i++) run_period(0, 0);
        chk_idle("ramp_done");

        lft_spd = 12'sd2047;
        set_en(1'b1);
        for (int i = 0; i < 35; i++) run_period(0, 0);
        chk("sat_hi_1983", lft_duty, 1983);
        lft_spd = -12'sd2048;
        for (int i = 0; i < 65; i++) run_period(0, 0);
        chk("sat_lo_64", lft_duty, 64);
        lft_spd = 12'sd500;
        for (int i = 0; i < 50; i++) run_period(0, 0);

        for (int i = 0; i < 20; i++) run_period(0, 1);
        chk("blanked_no_fault", OVR_I_shtdwn, 0);

        for (int i = 0; i < 20 && m_win != 9; i++) run_period(0, 0);
        for (int i = 0; i < 14; i++) run_period(1, 0);
        chk("window_split_no_fault", OVR_I_shtdwn, 0);
        for (int i = 0; i < 20 && m_win != 0; i++) run_period(0, 0);
        for (int i = 0; i < 8; i++) run_period(1, 0);
        chk("fault_shtdwn", OVR_I_shtdwn, 1);
        chk("fault_pwm_en", pwm_en, 0);
        chk("fault_lft", lft_duty, 1024);
        chk("fault_rght", rght_duty, 1024);

        pulse_clr();
        chk("clr_with_en_ignored", OVR_I_shtdwn, 1);
        for (int i = 0; i < 2; i++) run_period(0, 0);
        set_en(1'b0);
        pulse_clr();
        chk_idle("fault_cleared");

        set_en(1'b1);
        for (int i = 0; i < 5; i++) run_period(0, 0);
        chk("pre_reset_pwm_en", pwm_en, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle("async_reset");
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_state = M_DIS;
        m_l = 1024;
        m_r = 1024;
        m_cnt = 0;
        m_win = 0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
